serdiv_requester: RTL and testbench

// - Synthesizable initiator for serdiv_wrapper: accepts divide/remainder commands, drives the divider in-handshake, collects the result, returns it upstream.
// - Owns transaction-ID generation, label (taint) propagation, flush and hang detection; one operation in flight, matching the single-op serial divider.

---
 rtl/serdiv_req_pkg.sv | 30 +++
 rtl/serdiv_requester.sv | 216 +++++++++++++++++++++
 tb/tb_serdiv_requester.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serdiv_req_pkg.sv
// serdiv_req_pkg: shared types for the serial-divider requester.
// Holds FSM state codes, the divider opcode enum and the captured command attribute struct.
package serdiv_req_pkg;

    localparam int unsigned TRANS_ID_BITS = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        OP_UDIV = 2'd0,
        OP_DIV  = 2'd1,
        OP_UREM = 2'd2,
        OP_REM  = 2'd3
    } opcode_e;

    typedef struct packed {
        opcode_e opcode;
        logic    a_label;
        logic    b_label;
    } cmd_attr_t;

    typedef struct packed {
        logic label;
        logic id_err;
    } rsp_flags_t;

endpackage

// File: rtl/serdiv_requester.sv
// serdiv_requester: single-op initiator for serdiv_wrapper with ID generation, label propagation,
// flush and hang detection. Optional SERDIV_REQ_PERF_EN adds perf_last_o / perf_ops_o.
module serdiv_requester
    import serdiv_req_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned ID_W        = TRANS_ID_BITS,
    parameter int unsigned TIMEOUT_CYC = 2 * WIDTH + 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             cmd_vld_i,
    output logic             cmd_rdy_o,
    input  logic [WIDTH-1:0] cmd_a_i,
    input  logic [WIDTH-1:0] cmd_b_i,
    input  logic             cmd_a_label_i,
    input  logic             cmd_b_label_i,
    input  logic [1:0]       cmd_opcode_i,
    output logic             div_in_vld_o,
    input  logic             div_in_rdy_i,
    output logic [ID_W-1:0]  div_id_o,
    output logic [WIDTH-1:0] div_a_o,
    output logic [WIDTH-1:0] div_b_o,
    output logic             div_a_label_o,
    output logic             div_b_label_o,
    output logic [1:0]       div_opcode_o,
    output logic             div_flush_o,
    input  logic             div_out_vld_i,
    output logic             div_out_rdy_o,
    input  logic [ID_W-1:0]  div_id_i,
    input  logic [WIDTH-1:0] div_res_i,
    input  logic             div_res_label_i,
    output logic             rsp_vld_o,
    input  logic             rsp_rdy_i,
    output logic [WIDTH-1:0] rsp_res_o,
    output logic             rsp_label_o,
    output logic [ID_W-1:0]  rsp_id_o,
    output logic             err_o
`ifdef SERDIV_REQ_PERF_EN
   ,output logic [15:0]      perf_last_o,
    output logic [31:0]      perf_ops_o
`endif
);

    localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [1:0]       state_q, state_d;
    logic             cmd_rdy_q, div_in_vld_q, div_out_rdy_q, rsp_vld_q;
    logic             div_flush_q, div_flush_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    cmd_attr_t        attr_q, attr_d;
    logic [ID_W-1:0]  div_id_q, div_id_d, id_cnt_q, id_cnt_d;
    logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
    rsp_flags_t       rsp_q, rsp_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic             err_q, err_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic cmd_fire, div_in_fire, div_out_fire, rsp_fire, timeout_hit;

    // Handshakes only fire against the registered vld/rdy we actually present.
    assign cmd_fire     = cmd_vld_i & cmd_rdy_q;
    assign div_in_fire  = div_in_vld_q & div_in_rdy_i;
    assign div_out_fire = div_out_vld_i & div_out_rdy_q;
    assign rsp_fire     = rsp_vld_q & rsp_rdy_i;
    assign timeout_hit  = (TIMEOUT_CYC != 0) && (timer_q == TMR_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        div_flush_d = 1'b0;
        a_d         = a_q;
        b_d         = b_q;
        attr_d      = attr_q;
        div_id_d    = div_id_q;
        id_cnt_d    = id_cnt_q;
        rsp_res_d   = rsp_res_q;
        rsp_d       = rsp_q;
        rsp_id_d    = rsp_id_q;
        err_d       = err_q;
        timer_d     = timer_q;

        if (flush_i) begin
            // Flush beats any handshake in the same cycle; the ID counter keeps running.
            state_d     = ST_IDLE;
            div_flush_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        a_d            = cmd_a_i;
                        b_d            = cmd_b_i;
                        attr_d.opcode  = opcode_e'(cmd_opcode_i);
                        attr_d.a_label = cmd_a_label_i;
                        attr_d.b_label = cmd_b_label_i;
                        div_id_d       = id_cnt_q;
                        id_cnt_d       = id_cnt_q + ID_W'(1);
                        state_d        = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (div_in_fire) begin
                        timer_d = '0;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (div_out_fire) begin
                        rsp_res_d    = div_res_i;
                        rsp_d.label  = div_res_label_i | attr_q.a_label | attr_q.b_label;
                        rsp_d.id_err = (div_id_i != div_id_q);
                        rsp_id_d     = div_id_q;
                        err_d        = err_q | (div_id_i != div_id_q);
                        state_d      = ST_RESP;
                    end else if (timeout_hit) begin
                        div_flush_d = 1'b1;
                        err_d       = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_fire) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            cmd_rdy_q     <= 1'b0;
            div_in_vld_q  <= 1'b0;
            div_out_rdy_q <= 1'b0;
            rsp_vld_q     <= 1'b0;
            div_flush_q   <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            attr_q        <= '0;
            div_id_q      <= '0;
            id_cnt_q      <= '0;
            rsp_res_q     <= '0;
            rsp_q         <= '0;
            rsp_id_q      <= '0;
            err_q         <= 1'b0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            cmd_rdy_q     <= (state_d == ST_IDLE);
            div_in_vld_q  <= (state_d == ST_ISSUE);
            div_out_rdy_q <= (state_d == ST_WAIT);
            rsp_vld_q     <= (state_d == ST_RESP);
            div_flush_q   <= div_flush_d;
            a_q           <= a_d;
            b_q           <= b_d;
            attr_q        <= attr_d;
            div_id_q      <= div_id_d;
            id_cnt_q      <= id_cnt_d;
            rsp_res_q     <= rsp_res_d;
            rsp_q         <= rsp_d;
            rsp_id_q      <= rsp_id_d;
            err_q         <= err_d;
            timer_q       <= timer_d;
        end
    end

    assign cmd_rdy_o     = cmd_rdy_q;
    assign div_in_vld_o  = div_in_vld_q;
    assign div_id_o      = div_id_q;
    assign div_a_o       = a_q;
    assign div_b_o       = b_q;
    assign div_a_label_o = attr_q.a_label;
    assign div_b_label_o = attr_q.b_label;
    assign div_opcode_o  = attr_q.opcode;
    assign div_flush_o   = div_flush_q;
    assign div_out_rdy_o = div_out_rdy_q;
    assign rsp_vld_o     = rsp_vld_q;
    assign rsp_res_o     = rsp_res_q;
    assign rsp_label_o   = rsp_q.label;
    assign rsp_id_o      = rsp_id_q;
    assign err_o         = err_q;

`ifdef SERDIV_REQ_PERF_EN
    logic [15:0] perf_cnt_q, perf_last_q;
    logic [31:0] perf_ops_q;

    // Cycles spent in ISSUE+WAIT for the last captured result, saturating at 16 bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cnt_q  <= '0;
            perf_last_q <= '0;
            perf_ops_q  <= '0;
        end else if (!flush_i) begin
            if (cmd_fire) begin
                perf_cnt_q <= '0;
            end else if (((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && (perf_cnt_q != 16'hFFFF)) begin
                perf_cnt_q <= perf_cnt_q + 16'd1;
            end
            if ((state_q == ST_WAIT) && div_out_fire) begin
                perf_last_q <= (perf_cnt_q == 16'hFFFF) ? perf_cnt_q : perf_cnt_q + 16'd1;
            end
            if (rsp_fire) begin
                perf_ops_q <= perf_ops_q + 32'd1;
            end
        end
    end

    assign perf_last_o = perf_last_q;
    assign perf_ops_o  = perf_ops_q;
`endif

endmodule

// File: tb/tb_serdiv_requester.sv
// tb_serdiv_requester: randomized bench with a stubbed serial divider and a transaction-level model.
module tb_serdiv_requester;

    localparam int unsigned W   = 8;
    localparam int unsigned IDW = serdiv_req_pkg::TRANS_ID_BITS;
    localparam int unsigned TO  = 24;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           flush_i;
    logic           cmd_vld_i, cmd_rdy_o;
    logic [W-1:0]   cmd_a_i, cmd_b_i;
    logic           cmd_a_label_i, cmd_b_label_i;
    logic [1:0]     cmd_opcode_i;
    logic           div_in_vld_o, div_in_rdy_i;
    logic [IDW-1:0] div_id_o;
    logic [W-1:0]   div_a_o, div_b_o;
    logic           div_a_label_o, div_b_label_o;
    logic [1:0]     div_opcode_o;
    logic           div_flush_o;
    logic           div_out_vld_i, div_out_rdy_o;
    logic [IDW-1:0] div_id_i;
    logic [W-1:0]   div_res_i;
    logic           div_res_label_i;
    logic           rsp_vld_o, rsp_rdy_i;
    logic [W-1:0]   rsp_res_o;
    logic           rsp_label_o;
    logic [IDW-1:0] rsp_id_o;
    logic           err_o;
`ifdef SERDIV_REQ_PERF_EN
    logic [15:0]    perf_last_o;
    logic [31:0]    perf_ops_o;
`endif

    always #5 clk_i = ~clk_i;

    serdiv_requester #(.WIDTH(W), .ID_W(IDW), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .cmd_vld_i(cmd_vld_i), .cmd_rdy_o(cmd_rdy_o),
        .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i),
        .cmd_a_label_i(cmd_a_label_i), .cmd_b_label_i(cmd_b_label_i),
        .cmd_opcode_i(cmd_opcode_i),
        .div_in_vld_o(div_in_vld_o), .div_in_rdy_i(div_in_rdy_i),
        .div_id_o(div_id_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
        .div_a_label_o(div_a_label_o), .div_b_label_o(div_b_label_o),
        .div_opcode_o(div_opcode_o), .div_flush_o(div_flush_o),
        .div_out_vld_i(div_out_vld_i), .div_out_rdy_o(div_out_rdy_o),
        .div_id_i(div_id_i), .div_res_i(div_res_i), .div_res_label_i(div_res_label_i),
        .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i),
        .rsp_res_o(rsp_res_o), .rsp_label_o(rsp_label_o), .rsp_id_o(rsp_id_o),
        .err_o(err_o)
`ifdef SERDIV_REQ_PERF_EN
       ,.perf_last_o(perf_last_o), .perf_ops_o(perf_ops_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // RISC-V style divide/remainder used by the divider stub and by the expectation.
    function automatic logic [W-1:0] div_ref(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0:    return (b == 0) ? 8'hFF : a / b;
            2'd1:    if (b == 0) return 8'hFF;
                     else if (a == 8'h80 && b == 8'hFF) return 8'h80;
                     else return 8'(sa / sb);
            2'd2:    return (b == 0) ? a : a % b;
            default: if (b == 0) return a;
                     else if (a == 8'h80 && b == 8'hFF) return 8'h00;
                     else return 8'(sa % sb);
        endcase
    endfunction

    // Divider stub controls
    int       stub_lat   = 10;
    bit       stub_hang  = 1'b0;
    bit       stub_label = 1'b0;
    bit       stub_bad   = 1'b0;

    initial begin
        bit             busy, p_in, p_out;
        int             cnt;
        logic [W-1:0]   res;
        logic [IDW-1:0] id;
        busy = 0; p_in = 0; p_out = 0; cnt = 0; res = '0; id = '0;
        div_in_rdy_i = 1'b0; div_out_vld_i = 1'b0; div_id_i = '0; div_res_i = '0; div_res_label_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                busy = 0; p_in = 0; p_out = 0;
                div_in_rdy_i = 1'b0; div_out_vld_i = 1'b0;
            end else begin
                if (p_in) begin busy = 1; cnt = stub_lat; end
                if (p_out) begin busy = 0; div_out_vld_i = 1'b0; end
                if (div_flush_o) begin busy = 0; div_out_vld_i = 1'b0; end
                if (busy && !div_out_vld_i && !stub_hang) begin
                    if (cnt <= 1) begin
                        div_out_vld_i   = 1'b1;
                        div_res_i       = res;
                        div_id_i        = stub_bad ? ~id : id;
                        div_res_label_i = stub_label;
                    end else begin
                        cnt--;
                    end
                end
                div_in_rdy_i = !busy && ($urandom_range(0, 3) != 0);
                p_in  = div_in_vld_o && div_in_rdy_i;
                p_out = div_out_vld_i && div_out_rdy_o;
                if (p_in) begin
                    res = div_ref(div_opcode_o, div_a_o, div_b_o);
                    id  = div_id_o;
                end
            end
        end
    end

    // Transaction-level expectation
    int             id_model = 0;
    logic [W-1:0]   exp_res;
    logic           exp_label;
    logic [IDW-1:0] exp_id;

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic reset_dut();
        rst_ni = 1'b0; flush_i = 1'b0; cmd_vld_i = 1'b0; rsp_rdy_i = 1'b0;
        cmd_a_i = '0; cmd_b_i = '0; cmd_a_label_i = 1'b0; cmd_b_label_i = 1'b0; cmd_opcode_i = '0;
        tick(); tick();
        chk("rst_cmd_rdy", 32'(cmd_rdy_o), 0);
        chk("rst_div_in_vld", 32'(div_in_vld_o), 0);
        chk("rst_rsp_vld", 32'(rsp_vld_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_flush", 32'(div_flush_o), 0);
        chk("rst_div_id", 32'(div_id_o), 0);
        rst_ni = 1'b1;
        id_model = 0;
        tick();
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic la, input logic lb);
        int n = 0;
        while (!cmd_rdy_o && n < 60) begin tick(); n++; end
        chk("cmd_rdy_wait", 32'(cmd_rdy_o), 1);
        cmd_vld_i = 1'b1; cmd_opcode_i = op; cmd_a_i = a; cmd_b_i = b;
        cmd_a_label_i = la; cmd_b_label_i = lb;
        exp_res   = div_ref(op, a, b);
        exp_label = la | lb | stub_label;
        exp_id    = IDW'(id_model);
        id_model++;
        tick();
        cmd_vld_i = 1'b0;
        cmd_a_i = W'($urandom); cmd_b_i = W'($urandom);
        chk("cmd_rdy_drop", 32'(cmd_rdy_o), 0);
    endtask

    task automatic collect(input int hold);
        int n = 0;
        while (!rsp_vld_o && n < 100) begin tick(); n++; end
        chk("rsp_vld", 32'(rsp_vld_o), 1);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_vld", 32'(rsp_vld_o), 1);
            chk("hold_res", 32'(rsp_res_o), 32'(exp_res));
            chk("hold_cmd_rdy", 32'(cmd_rdy_o), 0);
        end
        chk("rsp_res", 32'(rsp_res_o), 32'(exp_res));
        chk("rsp_label", 32'(rsp_label_o), 32'(exp_label));
        chk("rsp_id", 32'(rsp_id_o), 32'(exp_id));
        rsp_rdy_i = 1'b1;
        tick();
        rsp_rdy_i = 1'b0;
        chk("rsp_drop", 32'(rsp_vld_o), 0);
        chk("cmd_rdy_back", 32'(cmd_rdy_o), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        int  n, cnt;
        bit  seen;
        reset_dut();

        // Directed cases
        stub_lat = 10; stub_label = 1'b0;
        send_cmd(2'd0, 8'h37, 8'h01, 1'b0, 1'b0); collect(0);
        send_cmd(2'd0, 8'h3B, 8'h01, 1'b1, 1'b0); collect(0);
        stub_label = 1'b1;
        send_cmd(2'd3, 8'hF9, 8'h02, 1'b0, 1'b0); collect(0);
        stub_label = 1'b0;
        send_cmd(2'd1, 8'h64, 8'hF9, 1'b0, 1'b1); collect(5);

        // Flush in the fourth WAIT cycle drops the op silently
        send_cmd(2'd2, 8'h55, 8'h07, 1'b0, 1'b0);
        n = 0;
        while (!div_out_rdy_o && n < 60) begin tick(); n++; end
        chk("flush_wait_entered", 32'(div_out_rdy_o), 1);
        repeat (3) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_pulse", 32'(div_flush_o), 1);
        chk("flush_no_rsp", 32'(rsp_vld_o), 0);
        chk("flush_idle", 32'(cmd_rdy_o), 1);
        tick();
        chk("flush_pulse_end", 32'(div_flush_o), 0);
        seen = 0;
        repeat (20) begin if (rsp_vld_o) seen = 1; tick(); end
        chk("flush_no_late_rsp", 32'(seen), 0);
        chk("flush_err", 32'(err_o), 0);
        send_cmd(2'd0, 8'hC8, 8'h0A, 1'b0, 1'b0); collect(1);

        // Randomized traffic, crosses several ID wraps
        for (int k = 0; k < 40; k++) begin
            logic [1:0]   op;
            logic [W-1:0] a, b;
            stub_lat   = $urandom_range(1, 12);
            stub_label = 1'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3));
            a  = W'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            send_cmd(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            collect($urandom_range(0, 3));
        end
        chk("err_clean", 32'(err_o), 0);

        // Hung divider: forced flush after TO WAIT cycles, sticky error, no response
        stub_hang = 1'b1;
        send_cmd(2'd0, 8'h10, 8'h02, 1'b0, 1'b0);
        n = 0; cnt = 0; seen = 0;
        while (!div_flush_o && n < 100) begin
            if (div_out_rdy_o) cnt++;
            if (rsp_vld_o) seen = 1;
            tick(); n++;
        end
        chk("to_flush", 32'(div_flush_o), 1);
        chk("to_wait_cycles", cnt, TO);
        chk("to_err", 32'(err_o), 1);
        chk("to_no_rsp", 32'(seen), 0);
        tick();
        chk("to_pulse_end", 32'(div_flush_o), 0);
        stub_hang = 1'b0;
        send_cmd(2'd0, 8'h21, 8'h03, 1'b0, 1'b0); collect(0);
        chk("to_err_sticky", 32'(err_o), 1);

        // Returned ID mismatch: result still delivered, error flagged
        reset_dut();
        stub_lat = 4; stub_label = 1'b0;
        send_cmd(2'd0, 8'h40, 8'h04, 1'b0, 1'b0); collect(0);
        chk("id_ok_err", 32'(err_o), 0);
        stub_bad = 1'b1;
        send_cmd(2'd2, 8'h41, 8'h04, 1'b1, 1'b0); collect(0);
        chk("id_bad_err", 32'(err_o), 1);
        stub_bad = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
